// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC unit: branch op encodings, FSM states, default vectors.
package npc_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef enum logic [OPW-1:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLTZ = 4'd3,
    BR_BGTZ = 4'd4,
    BR_BLEZ = 4'd5,
    BR_BGEZ = 4'd6,
    BR_J    = 4'd7,
    BR_JR   = 4'd8,
    BR_JALR = 4'd9
  } br_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

endpackage

// File: rtl/npc_unit_br_cond.sv
// Branch/jump condition resolver: taken flag and register-target select from op and operands.
module npc_unit_br_cond
  import npc_pkg::*;
(
  input  logic [OPW-1:0]  br_op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            taken,
  output logic            is_reg_target
);

  logic rs_zero;
  logic rs_neg;

  assign rs_zero = (rs_val == '0);
  assign rs_neg  = rs_val[XLEN-1];

  always_comb begin
    taken         = 1'b0;
    is_reg_target = 1'b0;
    case (br_op)
      BR_BEQ:  taken = (rs_val == rt_val);
      BR_BNE:  taken = (rs_val != rt_val);
      BR_BLTZ: taken = rs_neg;
      BR_BGTZ: taken = !rs_neg && !rs_zero;
      BR_BLEZ: taken = rs_neg || rs_zero;
      BR_BGEZ: taken = !rs_neg;
      BR_J:    taken = 1'b1;
      BR_JR, BR_JALR: begin
        taken         = 1'b1;
        is_reg_target = 1'b1;
      end
      default: taken = 1'b0;  // NONE and reserved codes 10-15
    endcase
  end

endmodule

// File: rtl/npc_unit.sv
// Fetch PC owner: decode redirects, stall with one-entry pending redirect, exception/ERET entry.
// Optional macro NPC_ALIGN_CHECK_EN flags misaligned JR/JALR/ERET targets on addr_err.
module npc_unit
  import npc_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF),
  parameter logic [AW-1:0] EXC_VEC  = AW'(EXC_VEC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            dec_fire,
  input  logic [OPW-1:0]  br_op,
  input  logic [AW-1:0]   pc_d,
  input  logic [15:0]     imm16_d,
  input  logic [25:0]     index26_d,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [AW-1:0]   epc,
  output logic [AW-1:0]   pc_f,
  output logic            redirect,
  output logic            pend_valid,
  output logic [AW-1:0]   link_d,
  output logic            addr_err
);

  state_e        state, state_n;
  logic [AW-1:0] pc_n;
  logic [AW-1:0] pend_tgt, pend_tgt_n;
  logic          pend_n;
  logic          pend_misal, pend_misal_n;
  logic          redirect_n;
  logic          addr_err_n;

  logic          taken;
  logic          is_reg_target;
  logic [AW-1:0] pc_d_plus4;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] j_tgt;
  logic [AW-1:0] dec_tgt;
  logic          dec_redir;
  logic          dec_misal;
  logic          epc_misal;

  npc_unit_br_cond u_br_cond (
    .br_op         (br_op),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .taken         (taken),
    .is_reg_target (is_reg_target)
  );

  assign link_d = pc_d + AW'(8);

  // Decode-stage target mux; J keeps the upper region bits of pc_d+4.
  always_comb begin
    pc_d_plus4  = pc_d + AW'(4);
    br_tgt      = pc_d_plus4 + {{(AW-18){imm16_d[15]}}, imm16_d, 2'b00};
    j_tgt       = pc_d_plus4;
    j_tgt[27:0] = {index26_d, 2'b00};
    if (is_reg_target)
      dec_tgt = AW'(rs_val);
    else if (br_op == BR_J)
      dec_tgt = j_tgt;
    else
      dec_tgt = br_tgt;
    dec_redir = dec_fire && taken;
  end

`ifdef NPC_ALIGN_CHECK_EN
  assign dec_misal = is_reg_target && (dec_tgt[1:0] != 2'b00);
  assign epc_misal = (epc[1:0] != 2'b00);
`else
  assign dec_misal = 1'b0;
  assign epc_misal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      pc_f       <= RESET_PC;
      pend_tgt   <= '0;
      pend_valid <= 1'b0;
      pend_misal <= 1'b0;
      redirect   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state      <= state_n;
      pc_f       <= pc_n;
      pend_tgt   <= pend_tgt_n;
      pend_valid <= pend_n;
      pend_misal <= pend_misal_n;
      redirect   <= redirect_n;
      addr_err   <= addr_err_n;
    end
  end

  // Next-PC priority: exception > ERET > pending/decode redirect > sequential > hold.
  always_comb begin
    state_n      = state;
    pc_n         = pc_f;
    pend_tgt_n   = pend_tgt;
    pend_n       = pend_valid;
    pend_misal_n = pend_misal;
    redirect_n   = 1'b0;
    addr_err_n   = 1'b0;

    if (exc_req) begin
      pc_n       = EXC_VEC;
      redirect_n = 1'b1;
      pend_n     = 1'b0;
      state_n    = ST_RUN;
    end else if (eret_req) begin
      pc_n       = epc;
      redirect_n = 1'b1;
      addr_err_n = epc_misal;
      pend_n     = 1'b0;
      state_n    = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (dec_redir) begin
            if (!stall_f) begin
              pc_n       = dec_tgt;
              redirect_n = 1'b1;
              addr_err_n = dec_misal;
            end else begin
              pend_tgt_n   = dec_tgt;
              pend_misal_n = dec_misal;
              pend_n       = 1'b1;
              state_n      = ST_PEND;
            end
          end else if (!stall_f) begin
            pc_n = pc_f + AW'(4);
          end
        end
        ST_PEND: begin
          if (stall_f) begin
            if (dec_redir) begin
              pend_tgt_n   = dec_tgt;
              pend_misal_n = dec_misal;
            end
          end else begin
            pc_n       = dec_redir ? dec_tgt : pend_tgt;
            addr_err_n = dec_redir ? dec_misal : pend_misal;
            redirect_n = 1'b1;
            pend_n     = 1'b0;
            state_n    = ST_RUN;
          end
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: directed steps push expectations, a monitor checks after each edge.
module tb_npc_unit;
  import npc_pkg::*;

  localparam int unsigned AW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall_f;
  logic            dec_fire;
  logic [3:0]      br_op;
  logic [AW-1:0]   pc_d;
  logic [15:0]     imm16_d;
  logic [25:0]     index26_d;
  logic [31:0]     rs_val;
  logic [31:0]     rt_val;
  logic            exc_req;
  logic            eret_req;
  logic [AW-1:0]   epc;
  logic [AW-1:0]   pc_f;
  logic            redirect;
  logic            pend_valid;
  logic [AW-1:0]   link_d;
  logic            addr_err;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        red;
    logic        pend;
    logic        err;
    logic        chk_link;
    logic [31:0] link;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef NPC_ALIGN_CHECK_EN
  localparam logic ALIGN_ON = 1'b1;
`else
  localparam logic ALIGN_ON = 1'b0;
`endif

  npc_unit u_dut (
    .clk        (clk),
    .reset      (reset),
    .stall_f    (stall_f),
    .dec_fire   (dec_fire),
    .br_op      (br_op),
    .pc_d       (pc_d),
    .imm16_d    (imm16_d),
    .index26_d  (index26_d),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .pc_f       (pc_f),
    .redirect   (redirect),
    .pend_valid (pend_valid),
    .link_d     (link_d),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  // Monitor: every edge produces an output state; compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (pc_f !== e.pc) begin
        errors++;
        $display("FAIL %s pc_f: got %h expected %h", e.tag, pc_f, e.pc);
      end
      checks++;
      if (redirect !== e.red) begin
        errors++;
        $display("FAIL %s redirect: got %b expected %b", e.tag, redirect, e.red);
      end
      checks++;
      if (pend_valid !== e.pend) begin
        errors++;
        $display("FAIL %s pend_valid: got %b expected %b", e.tag, pend_valid, e.pend);
      end
      checks++;
      if (addr_err !== e.err) begin
        errors++;
        $display("FAIL %s addr_err: got %b expected %b", e.tag, addr_err, e.err);
      end
      if (e.chk_link) begin
        checks++;
        if (link_d !== e.link) begin
          errors++;
          $display("FAIL %s link_d: got %h expected %h", e.tag, link_d, e.link);
        end
      end
    end
  end

  task automatic idle();
    reset = 1'b0; stall_f = 1'b0; dec_fire = 1'b0; br_op = BR_NONE;
    pc_d = '0; imm16_d = '0; index26_d = '0; rs_val = '0; rt_val = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;
  endtask

  task automatic dec(input logic [3:0] op, input logic [31:0] pcd, input logic [15:0] imm,
                     input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt);
    dec_fire = 1'b1; br_op = op; pc_d = pcd; imm16_d = imm; index26_d = idx;
    rs_val = rs; rt_val = rt;
  endtask

  // Inputs are set by the caller before this; it pushes the expectation for the coming edge.
  task automatic step(input string tag, input logic [31:0] pc, input logic red,
                      input logic pend, input logic err,
                      input logic chk_link = 1'b0, input logic [31:0] link = '0);
    exp_t e;
    e.tag = tag; e.pc = pc; e.red = red; e.pend = pend; e.err = err;
    e.chk_link = chk_link; e.link = link;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    step("reset", 32'h3000, 0, 0, 0);
    step("seq1", 32'h3004, 0, 0, 0);
    step("seq2", 32'h3008, 0, 0, 0);
    step("seq3", 32'h300C, 0, 0, 0);

    dec(BR_BEQ, 32'h3010, 16'hFFFC, '0, 32'd5, 32'd5);
    step("beq_taken", 32'h3004, 1, 0, 0, 1, 32'h3018);
    dec(BR_BEQ, 32'h3010, 16'hFFFC, '0, 32'd5, 32'd6);
    step("beq_not", 32'h3008, 0, 0, 0);
    dec(BR_BGTZ, 32'h3010, 16'h0004, '0, 32'd0, 32'd0);
    step("bgtz_zero", 32'h300C, 0, 0, 0);
    dec(BR_BLEZ, 32'h3010, 16'h0004, '0, 32'h8000_0000, 32'd0);
    step("blez_neg", 32'h3024, 1, 0, 0);
    dec(BR_BGEZ, 32'h3010, 16'h0004, '0, 32'hFFFF_FFFF, 32'd0);
    step("bgez_neg", 32'h3028, 0, 0, 0);
    dec(BR_BLTZ, 32'h3100, 16'h0000, '0, 32'hFFFF_FFFF, 32'd0);
    step("bltz_neg", 32'h3104, 1, 0, 0);
    dec(BR_JR, 32'h3010, 16'h0000, '0, 32'h3100, 32'd0);
    step("jr", 32'h3100, 1, 0, 0);
    dec(BR_J, 32'h3020, 16'h0000, 26'h0000D00, 32'd0, 32'd0);
    step("jal", 32'h3400, 1, 0, 0, 1, 32'h3028);
    step("after_jal", 32'h3404, 0, 0, 0);

    // Taken BNE held by stall for two cycles, released afterwards.
    stall_f = 1'b1;
    dec(BR_BNE, 32'h3030, 16'h0010, '0, 32'd1, 32'd2);
    step("bne_stall1", 32'h3404, 0, 1, 0);
    stall_f = 1'b1;
    step("bne_stall2", 32'h3404, 0, 1, 0);
    step("bne_release", 32'h3074, 1, 0, 0);
    step("after_bne", 32'h3078, 0, 0, 0);

    // Exception while a redirect is pending and fetch is stalled.
    stall_f = 1'b1;
    dec(BR_BEQ, 32'h3040, 16'h0000, '0, 32'd7, 32'd7);
    step("pend_for_exc", 32'h3078, 0, 1, 0);
    stall_f = 1'b1; exc_req = 1'b1;
    dec(BR_BEQ, 32'h3040, 16'h0000, '0, 32'd7, 32'd7);
    step("exc_over_pend", 32'h4180, 1, 0, 0);
    step("after_exc", 32'h4184, 0, 0, 0);
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h5000;
    step("exc_and_eret", 32'h4180, 1, 0, 0);
    eret_req = 1'b1; epc = 32'h5000; stall_f = 1'b1;
    step("eret", 32'h5000, 1, 0, 0);

    // Pending target is last-wins while stalled.
    stall_f = 1'b1;
    dec(BR_J, 32'h5000, 16'h0000, 26'h0000400, 32'd0, 32'd0);
    step("pend_first", 32'h5000, 0, 1, 0);
    stall_f = 1'b1;
    dec(BR_J, 32'h5000, 16'h0000, 26'h0000500, 32'd0, 32'd0);
    step("pend_overwrite", 32'h5000, 0, 1, 0);
    step("pend_lastwin", 32'h1400, 1, 0, 0);

    // Same-cycle decode redirect beats the pending target on release.
    stall_f = 1'b1;
    dec(BR_J, 32'h1400, 16'h0000, 26'h0000600, 32'd0, 32'd0);
    step("pend_again", 32'h1400, 0, 1, 0);
    dec(BR_JR, 32'h1400, 16'h0000, '0, 32'h2200, 32'd0);
    step("dec_beats_pend", 32'h2200, 1, 0, 0);

    // Alignment flag only in the checked build.
    dec(BR_JR, 32'h3010, 16'h0000, '0, 32'h3102, 32'd0);
    step("jr_misaligned", 32'h3102, 1, 0, ALIGN_ON);
    step("after_misal", 32'h3106, 0, 0, 0);
    eret_req = 1'b1; epc = 32'h5001;
    step("eret_misaligned", 32'h5001, 1, 0, ALIGN_ON);
    step("pc_wrap_prep", 32'h5005, 0, 0, 0);
    dec(BR_JR, 32'h3010, 16'h0000, '0, 32'hFFFF_FFFC, 32'd0);
    step("jr_top", 32'hFFFF_FFFC, 1, 0, 0);
    step("pc_wrap", 32'h0000_0000, 0, 0, 0);

    reset = 1'b1; exc_req = 1'b1; eret_req = 1'b1; epc = 32'h5000;
    step("reset_override", 32'h3000, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Parametrised successor to the decode-stage next-PC logic.
- Owns the fetch PC register and resolves all branch/jump kinds internally from a compact op code and register operands; no pre-computed compare flags.
- Adds stall handling, a one-entry pending-redirect buffer, and exception/ERET redirection.
- Sits between the F and D stages; its PC output drives instruction memory.

Parameters:
- AW, 32, PC/address width (>=28).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception entry vector.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_f  in  1  hold fetch PC this cycle.
- dec_fire  in  1  D-stage instruction valid and advancing this cycle.
- br_op  in  4  0 NONE, 1 BEQ, 2 BNE, 3 BLTZ, 4 BGTZ, 5 BLEZ, 6 BGEZ, 7 J/JAL, 8 JR, 9 JALR; 10-15 treated as NONE.
- pc_d  in  AW  PC of the D-stage instruction.
- imm16_d  in  16  branch offset.
- index26_d  in  26  jump index.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- exc_req  in  1  exception taken (from M stage).
- eret_req  in  1  ERET commit.
- epc  in  AW  return address for ERET.
- pc_f  out  AW  current fetch PC (registered).
- redirect  out  1  registered pulse: pc_f was loaded non-sequentially last edge.
- pend_valid  out  1  a captured redirect is waiting.
- link_d  out  AW  pc_d+8, combinational, for JAL/JALR write-back.
- addr_err  out  1  see Optional Feature; constant 0 when compiled out.

Behaviour:
- Reset (sync, active-high):
  - pc_f=RESET_PC; redirect=0; pend_valid=0; addr_err=0; state=RUN.
  - Reset overrides every other input in the same cycle.
- Taken condition is computed combinationally in D; signed compares are on rs_val:
  - BEQ: rs==rt. BNE: rs!=rt.
  - BLTZ: rs[31]. BGEZ: !rs[31].
  - BGTZ: !rs[31] && rs!=0. BLEZ: rs[31] || rs==0.
  - J, JR, JALR are always taken.
- Target:
  - Branch: pc_d+4 + (sign-extend(imm16_d)<<2), modulo 2^AW.
  - J: {pc_d_plus4[AW-1:28], index26_d, 2'b00}.
  - JR/JALR: rs_val[AW-1:0].
- Decode redirect is valid only when dec_fire=1 and the condition is taken.
- Next-PC priority per edge: reset > exc_req (EXC_VEC) > eret_req (epc) > pending/decode redirect > pc_f+4 > hold.
  - exc_req and eret_req ignore stall_f.
  - exc_req and eret_req clear pend_valid and discard any same-cycle decode redirect.
  - exc_req and eret_req together: exc_req wins.
- State machine:
  - RUN, decode redirect with stall_f=0: pc_f<=target, redirect<=1.
  - RUN, decode redirect with stall_f=1: latch target into pend_tgt; pend_valid<=1; go to PEND. pc_f holds.
  - RUN, no redirect: pc_f<=pc_f+4 if !stall_f, else hold. redirect<=0.
  - PEND, stall_f=1: hold. A new decode redirect overwrites pend_tgt (last-wins).
  - PEND, stall_f=0: pc_f<=pend_tgt, redirect<=1, pend_valid<=0, go to RUN. A same-cycle decode redirect takes precedence over pend_tgt.
  - Any state, exc_req/eret_req: load vector/epc, redirect<=1, go to RUN.
- pc_f+4 wraps modulo 2^AW; no overflow flag.
- Latency: a redirect resolved in D is visible on pc_f one edge later. No bubble is inserted by this block; flushing is the hazard unit's job.

Optional Feature:
- Macro NPC_ALIGN_CHECK_EN.
- Enabled:
  - A JR/JALR/ERET target with bits[1:0]!=0 sets addr_err<=1 (registered, one-cycle pulse aligned with redirect).
  - pc_f is still loaded with the raw target; the exception unit then raises AdEL.
- Disabled: addr_err tied 0; target bits[1:0] pass through unchanged.

Decomposition:
- Shared package npc_pkg: br_op encodings (BR_NONE..BR_JALR), state encoding (ST_RUN, ST_PEND), default RESET_PC/EXC_VEC constants.
- One natural sub-module, br_cond: purely combinational; takes br_op, rs_val, rt_val; outputs taken and is_reg_target.
- The target mux and sequential logic stay in npc_unit.

Test Plan:
- Reset then release with stall_f=0 for 3 cycles: pc_f = 3000, 3004, 3008, 300C; redirect=0.
- BEQ, pc_d=3010, imm=0xFFFC, rs=rt=5, dec_fire=1: next pc_f=3004, redirect=1. Repeat with rt=6: pc_f=prev+4.
- BGTZ with rs=0 is not taken; BLEZ with rs=0x80000000 is taken; JR with rs=0x3100 gives pc_f=0x3100. JAL with pc_d=3020 gives link_d=3028.
- Taken BNE while stall_f=1 for 2 cycles: pend_valid=1 and pc_f frozen; after stall drops, pc_f=target on the next edge and pend_valid=0.
- exc_req coincident with a pending redirect and stall_f=1: pc_f=4180, pend_valid=0. exc_req+eret_req together: pc_f=4180.
- NPC_ALIGN_CHECK_EN build, JR rs=0x3102: addr_err=1 for one cycle, pc_f=0x3102. Non-macro build: addr_err stays 0.
